// File: rtl/core_isa_pkg.sv
// Shared ISA constants, opcode encodings and fetch FSM state type for the
// 14-bit core.
package core_isa_pkg;

    localparam int PC_W    = 11;
    localparam int IW      = 14;
    localparam int STACK_D = 8;

    // Control-transfer encodings.
    localparam logic [2:0]    OP_GOTO   = 3'b101;   // ir[13:11]
    localparam logic [2:0]    OP_CALL   = 3'b100;   // ir[13:11]
    localparam logic [IW-1:0] OP_RETURN = 14'h0008;
    localparam logic [IW-1:0] OP_RETFIE = 14'h0009;
    localparam logic [3:0]    OP_RETLW  = 4'b1101;  // ir[13:10]
    localparam logic [IW-1:0] NOP       = 14'h0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } fetch_state_e;

    // True for any instruction that pops the call stack.
    function automatic logic is_return(input logic [IW-1:0] w);
        return (w == OP_RETURN) || (w == OP_RETFIE) || (w[IW-1 -: 4] == OP_RETLW);
    endfunction

endpackage

// File: rtl/call_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop from an empty stack still returns the entry at ptr-1.
// Both cases raise sticky flags that only reset clears.
module call_stack
    import core_isa_pkg::*;
#(
    parameter int W     = 11,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         ovf,
    output logic         unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;      // next free slot
    logic [CW-1:0] count;    // live entries, saturates at DEPTH and 0

    assign top = mem[ptr - PW'(1)];

    // Entry storage: written on push only, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (count == CW'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end else if (pop) begin
            ptr <= ptr - PW'(1);
            if (count == '0) begin
                unf <= 1'b1;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, instruction register and control-transfer decode.
// The pc register addresses the ROM directly; the returned word is latched
// into ir_out. Any redirect inserts exactly one bubble while the target word
// is fetched.
module fetch_sequencer
    import core_isa_pkg::*;
#(
    parameter int PC_W    = core_isa_pkg::PC_W,
    parameter int IW      = core_isa_pkg::IW,
    parameter int STACK_D = core_isa_pkg::STACK_D
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] rom_addr_out,
    input  logic [IW-1:0]   rom_data_in,
    output logic [IW-1:0]   ir_out,
    output logic            ir_valid,
    input  logic            stall_in,
    input  logic            skip_in,
    input  logic            pcl_we,
    input  logic [7:0]      pcl_data,
    input  logic [4:0]      pclath_in,
    output logic            stack_ovf,
    output logic            stack_unf,
    output fetch_state_e    state_dbg
);

    fetch_state_e    state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic [IW-1:0]   ir_nx;
    logic            valid_nx;
    logic            push, pop;
    logic [PC_W-1:0] stack_top;
    logic            unused_pclath;

    // Only the low three PCLATH bits reach the 11-bit pc.
    assign unused_pclath = ^pclath_in[4:3];

    assign rom_addr_out = pc;
    assign state_dbg    = state;

    call_stack #(
        .W     (PC_W),
        .DEPTH (STACK_D)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .top       (stack_top),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

    // State, pc and instruction register; everything holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= '0;
            ir_out   <= NOP;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir_out   <= ir_nx;
            ir_valid <= valid_nx;
        end
    end

    // Next-state and redirect decode. In RUN, pc already points one past
    // the instruction in ir_out, so it is the return address for CALL.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir_out;
        valid_nx = ir_valid;
        push     = 1'b0;
        pop      = 1'b0;
        if (!stall_in) begin
            case (state)
                BOOT, BUBBLE: begin
                    ir_nx    = rom_data_in;
                    valid_nx = 1'b1;
                    pc_nx    = pc + PC_W'(1);
                    state_nx = RUN;
                end
                RUN: begin
                    ir_nx    = rom_data_in;
                    valid_nx = 1'b1;
                    pc_nx    = pc + PC_W'(1);
                    if (pcl_we) begin
                        pc_nx    = PC_W'({pclath_in[2:0], pcl_data});
                        ir_nx    = NOP;
                        valid_nx = 1'b0;
                        state_nx = BUBBLE;
                    end else if (ir_valid && ir_out[IW-1 -: 3] == OP_GOTO) begin
                        pc_nx    = ir_out[PC_W-1:0];
                        ir_nx    = NOP;
                        valid_nx = 1'b0;
                        state_nx = BUBBLE;
                    end else if (ir_valid && ir_out[IW-1 -: 3] == OP_CALL) begin
                        push     = 1'b1;
                        pc_nx    = ir_out[PC_W-1:0];
                        ir_nx    = NOP;
                        valid_nx = 1'b0;
                        state_nx = BUBBLE;
                    end else if (ir_valid && is_return(ir_out)) begin
                        pop      = 1'b1;
                        pc_nx    = stack_top;
                        ir_nx    = NOP;
                        valid_nx = 1'b0;
                        state_nx = BUBBLE;
                    end else if (skip_in) begin
                        ir_nx    = NOP;
                        valid_nx = 1'b0;
                    end
                end
                default: state_nx = BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural ROM. Expected
// instruction words go into exp_q as each scenario is set up; the monitor
// pops one whenever a valid instruction is consumed by execute.
module tb_fetch_sequencer;
    import core_isa_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0]  rom_addr_out;
    logic [13:0]  rom_data_in;
    logic [13:0]  ir_out;
    logic         ir_valid;
    logic         stall_in = 1'b0;
    logic         skip_in = 1'b0;
    logic         pcl_we = 1'b0;
    logic [7:0]   pcl_data = 8'h00;
    logic [4:0]   pclath_in = 5'h00;
    logic         stack_ovf;
    logic         stack_unf;
    fetch_state_e state_dbg;

    logic [13:0] rom [2048];
    assign rom_data_in = rom[rom_addr_out];

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_addr_out (rom_addr_out),
        .rom_data_in  (rom_data_in),
        .ir_out       (ir_out),
        .ir_valid     (ir_valid),
        .stall_in     (stall_in),
        .skip_in      (skip_in),
        .pcl_we       (pcl_we),
        .pcl_data     (pcl_data),
        .pclath_in    (pclath_in),
        .stack_ovf    (stack_ovf),
        .stack_unf    (stack_unf),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [13:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Address / valid after each clock of the reset + CALL scenario.
    int a_tab [9] = '{1, 2, 3, 4, 'h20, 'h21, 4, 5, 6};
    int v_tab [9] = '{1, 1, 1, 1, 0, 1, 0, 1, 1};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Filler words: plain (non-transfer) opcodes that encode their address.
    function automatic logic [13:0] fillw(input int a);
        return 14'h1000 | 14'(a);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fill();
        for (int i = 0; i < 2048; i++) rom[i] = fillw(i);
    endtask

    // CALL chain 0x00 -> 0x10 -> ... -> 0x90, RETURN after every call site.
    task automatic load_call_chain();
        load_fill();
        for (int k = 0; k < 9; k++) begin
            rom[16 * k]     = 14'h2000 | 14'(16 * (k + 1));
            rom[16 * k + 1] = 14'h0008;
        end
        rom['h90] = 14'h0008;
    endtask

    task automatic start_phase();
        rst_n     = 1'b0;
        stall_in  = 1'b0;
        skip_in   = 1'b0;
        pcl_we    = 1'b0;
        pcl_data  = 8'h00;
        pclath_in = 5'h00;
        step();
        check("rst_addr",  16'(rom_addr_out), 16'h0000);
        check("rst_valid", 16'(ir_valid),     16'h0000);
        check("rst_ir",    16'(ir_out),       16'h0000);
        check("rst_ovf",   16'(stack_ovf),    16'h0000);
        check("rst_unf",   16'(stack_unf),    16'h0000);
        check("rst_state", 16'(state_dbg),    16'(BOOT));
        rst_n = 1'b1;
    endtask

    task automatic end_phase();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d words never seen, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [13:0] e;
        if (rst_n && ir_valid && !stall_in) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ir_unexpected: got %h expected none", ir_out);
            end else begin
                e = exp_q.pop_front();
                check("ir_out", 16'(ir_out), 16'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset release, sequential fetch, CALL into RETLW and back.
        load_fill();
        rom[0]     = 14'h01A5;
        rom[1]     = 14'h0103;
        rom[3]     = 14'h2020;
        rom['h20]  = 14'h3400;
        start_phase();
        exp_q.push_back(14'h01A5);
        exp_q.push_back(14'h0103);
        exp_q.push_back(fillw(2));
        exp_q.push_back(14'h2020);
        exp_q.push_back(14'h3400);
        exp_q.push_back(fillw(4));
        exp_q.push_back(fillw(5));
        for (int k = 0; k < 9; k++) begin
            step();
            check("seq_addr",  16'(rom_addr_out), 16'(a_tab[k]));
            check("seq_valid", 16'(ir_valid),     16'(v_tab[k]));
        end
        end_phase();

        // Skip at 0xb, GOTO at 0x12, stall, PCL write.
        load_fill();
        rom['h0b] = 14'h0BA2;
        rom['h12] = 14'h2804;
        start_phase();
        for (int i = 0; i <= 'h0a; i++) exp_q.push_back(fillw(i));
        exp_q.push_back(14'h0BA2);
        for (int i = 'h0d; i <= 'h11; i++) exp_q.push_back(fillw(i));
        exp_q.push_back(14'h2804);
        exp_q.push_back(fillw(4));
        exp_q.push_back(fillw(5));
        exp_q.push_back(fillw('h110));
        repeat (12) step();
        check("skip_pre_addr", 16'(rom_addr_out), 16'h000c);
        skip_in = 1'b1;
        step();
        skip_in = 1'b0;
        check("skip_valid", 16'(ir_valid),     16'h0000);
        check("skip_ir",    16'(ir_out),       16'h0000);
        check("skip_addr",  16'(rom_addr_out), 16'h000d);
        repeat (6) step();
        check("goto_addr", 16'(rom_addr_out), 16'h0013);
        step();
        check("goto_bubble_valid", 16'(ir_valid),     16'h0000);
        check("goto_bubble_addr",  16'(rom_addr_out), 16'h0004);
        check("goto_bubble_state", 16'(state_dbg),    16'(BUBBLE));
        repeat (2) step();
        check("goto_after_addr", 16'(rom_addr_out), 16'h0006);
        stall_in = 1'b1;
        skip_in  = 1'b1;
        repeat (3) begin
            step();
            check("stall_addr",  16'(rom_addr_out), 16'h0006);
            check("stall_ir",    16'(ir_out),       16'(fillw(5)));
            check("stall_valid", 16'(ir_valid),     16'h0001);
        end
        stall_in  = 1'b0;
        skip_in   = 1'b0;
        pcl_we    = 1'b1;
        pclath_in = 5'h01;
        pcl_data  = 8'h10;
        step();
        pcl_we = 1'b0;
        check("pcl_addr",  16'(rom_addr_out), 16'h0110);
        check("pcl_valid", 16'(ir_valid),     16'h0000);
        step();
        check("pcl_next_addr", 16'(rom_addr_out), 16'h0111);
        end_phase();

        // Nine nested CALLs then nine RETURNs: overflow and underflow.
        load_call_chain();
        start_phase();
        for (int k = 0; k < 9; k++) exp_q.push_back(14'h2000 | 14'(16 * (k + 1)));
        for (int j = 0; j < 9; j++) exp_q.push_back(14'h0008);
        for (int k = 0; k < 9; k++) begin
            repeat (2) step();
            check("call_target", 16'(rom_addr_out), 16'(16 * (k + 1)));
            check("call_ovf",    16'(stack_ovf),    16'(k == 8));
        end
        for (int j = 1; j <= 9; j++) begin
            repeat (2) step();
            check("ret_addr", 16'(rom_addr_out), (j <= 8) ? 16'('h91 - 16 * j) : 16'h0081);
            check("ret_unf",  16'(stack_unf),    16'(j == 9));
        end
        check("ovf_sticky", 16'(stack_ovf), 16'h0001);
        end_phase();

        // Asynchronous reset in the middle of the CALL chain.
        load_call_chain();
        start_phase();
        for (int k = 0; k < 9; k++) exp_q.push_back(14'h2000 | 14'(16 * (k + 1)));
        repeat (19) step();
        check("pre_reset_ovf", 16'(stack_ovf), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_addr",  16'(rom_addr_out), 16'h0000);
        check("async_valid", 16'(ir_valid),     16'h0000);
        check("async_ovf",   16'(stack_ovf),    16'h0000);
        check("async_unf",   16'(stack_unf),    16'h0000);
        check("async_state", 16'(state_dbg),    16'(BOOT));
        rom[0] = 14'h0008;
        exp_q.push_back(14'h0008);
        #1;
        rst_n = 1'b1;
        step();
        check("post_reset_addr", 16'(rom_addr_out), 16'h0001);
        step();
        check("post_reset_empty_unf", 16'(stack_unf), 16'h0001);
        end_phase();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
